face_select_ctrl: RTL

Upstream control stage for the VGA face display: it turns raw slide-switch inputs into the 2-bit `face_select` code consumed by the display system's `face_select_face_select` conduit. It synchronises and debounces the switches, optionally auto-cycles through the four faces on a frame timer, and changes the output only at a vertical-sync boundary so a face never switches mid-frame.

---
 rtl/face_select_ctrl.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/face_select_ctrl.sv
// face_select_ctrl: synchronises and debounces the face switches and applies the face code only at a VGA frame start.
// Define FACE_AUTO_CYCLE_EN to build the auto-cycle mode (sw_auto path, mode FSM and frame counter).

module face_select_debounce #(
    parameter int WIDTH  = 1,
    parameter int CYCLES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] i_raw,
    output logic [WIDTH-1:0] o_stable
);
    localparam int CW = $clog2(CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(CYCLES - 1);

    logic [WIDTH-1:0] r_sync1;
    logic [WIDTH-1:0] r_sync2;
    logic [WIDTH-1:0] r_prev;
    logic [WIDTH-1:0] r_stable;
    logic [CW-1:0]    r_cnt;

    // NOTE: every register here uses <= so all flops sample pre-edge values, like the hardware does.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1  <= '0;
            r_sync2  <= '0;
            r_prev   <= '0;
            r_stable <= '0;
            r_cnt    <= '0;
        end else begin
            r_sync1 <= i_raw;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
            if (r_sync2 == r_stable || r_sync2 != r_prev) begin
                r_cnt <= '0;
            end else if (r_cnt == CNT_LAST) begin
                r_stable <= r_sync2;
                r_cnt    <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign o_stable = r_stable;
endmodule

module face_select_ctrl #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int CYCLE_FRAMES    = 120
) (
    input  logic       clk_clk,
    input  logic       reset_reset_n,
    input  logic [1:0] sw_face,
    input  logic       sw_auto,
    input  logic       vga_vs,
    output logic [1:0] face_select,
    output logic       face_changed
);
    logic [1:0] w_face_stable;
    logic       r_vs_sync1;
    logic       r_vs_sync2;
    logic       r_vs_prev;
    logic       r_frame_start;
    logic [1:0] r_face_select;
    logic       r_face_changed;

    face_select_debounce #(
        .WIDTH  (2),
        .CYCLES (DEBOUNCE_CYCLES)
    ) u_face_db (
        .clk      (clk_clk),
        .rst_n    (reset_reset_n),
        .i_raw    (sw_face),
        .o_stable (w_face_stable)
    );

    // vga_vs idles high, so its synchroniser resets to 1 to avoid a false frame start.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            r_vs_sync1    <= 1'b1;
            r_vs_sync2    <= 1'b1;
            r_vs_prev     <= 1'b1;
            r_frame_start <= 1'b0;
        end else begin
            r_vs_sync1    <= vga_vs;
            r_vs_sync2    <= r_vs_sync1;
            r_vs_prev     <= r_vs_sync2;
            r_frame_start <= r_vs_prev & ~r_vs_sync2;
        end
    end

`ifdef FACE_AUTO_CYCLE_EN
    localparam int FW = (CYCLE_FRAMES > 1) ? $clog2(CYCLE_FRAMES) : 1;
    localparam logic [FW-1:0] FRAME_LAST = FW'(CYCLE_FRAMES - 1);

    typedef enum logic {
        MANUAL = 1'b0,
        AUTO   = 1'b1
    } mode_e;

    logic          w_auto_stable;
    mode_e         r_state;
    logic [FW-1:0] r_frame_cnt;

    face_select_debounce #(
        .WIDTH  (1),
        .CYCLES (DEBOUNCE_CYCLES)
    ) u_auto_db (
        .clk      (clk_clk),
        .rst_n    (reset_reset_n),
        .i_raw    (sw_auto),
        .o_stable (w_auto_stable)
    );

    // The frame-start update looks at r_state before this edge's mode transition.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            r_state        <= MANUAL;
            r_frame_cnt    <= '0;
            r_face_select  <= 2'd0;
            r_face_changed <= 1'b0;
        end else begin
            r_face_changed <= 1'b0;
            if (r_frame_start) begin
                if (r_state == AUTO) begin
                    if (r_frame_cnt == FRAME_LAST) begin
                        r_frame_cnt    <= '0;
                        r_face_select  <= r_face_select + 2'd1;
                        r_face_changed <= 1'b1;
                    end else begin
                        r_frame_cnt <= r_frame_cnt + 1'b1;
                    end
                end else begin
                    r_face_select  <= w_face_stable;
                    r_face_changed <= (w_face_stable != r_face_select);
                end
            end
            case (r_state)
                MANUAL: begin
                    if (w_auto_stable) begin
                        r_state     <= AUTO;
                        r_frame_cnt <= '0;
                    end
                end
                AUTO: begin
                    if (!w_auto_stable) begin
                        r_state <= MANUAL;
                    end
                end
                default: r_state <= MANUAL;
            endcase
        end
    end
`else
    logic w_unused;
    assign w_unused = sw_auto ^ (CYCLE_FRAMES > 1);

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            r_face_select  <= 2'd0;
            r_face_changed <= 1'b0;
        end else begin
            r_face_changed <= 1'b0;
            if (r_frame_start) begin
                r_face_select  <= w_face_stable;
                r_face_changed <= (w_face_stable != r_face_select);
            end
        end
    end
`endif

    assign face_select  = r_face_select;
    assign face_changed = r_face_changed;
endmodule
